uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side consumer of the 16x oversample enable `rxclk_en` from the baud generator.
- Synchronises the asynchronous serial line, validates the start bit, and samples each data bit at mid-bit.
- Presents the received byte with a ready flag that the host clears, plus sticky framing-error and overrun flags.
- Sits between the pad and the host/CPU-side logic, all in the 50 MHz domain.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first; legal range 5..8.
- SYNC_STAGES, 2, flops in the rx input synchroniser; legal range >=2.

Ports:
- clk_50m  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- rxclk_en  input  1  single-cycle enable pulse, 16 per bit period.
- rx  input  1  serial line, idle high, asynchronous to clk_50m.
- rdy_clr  input  1  host acknowledge; clears rdy, overrun and frame_err.
- data  output  DATA_BITS  last correctly framed byte.
- rdy  output  1  a new byte is held in data.
- frame_err  output  1  sticky; stop bit sampled low.
- overrun  output  1  sticky; a byte completed while rdy was already 1.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync deassert by the integrator): all outputs 0; state IDLE; sample counter 0; bit index 0; shift register 0; synchroniser flops preset to 1 (line idle).
- rx passes through SYNC_STAGES flops to give rx_s. All FSM logic uses rx_s only.
- The FSM advances only on cycles with rxclk_en=1. On other cycles all state holds, except the rdy_clr effects.
- States are IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on a tick with rx_s=0, go to START with sample=1.
- START: on a tick with rx_s=1, this is a false start; go to IDLE. On a tick with rx_s=0 and sample=7, go to DATA with sample=0 and bit index 0. This makes 8 consecutive low ticks (mid start bit). Otherwise sample+1.
- DATA: on a tick with sample=15, shift rx_s into shift[bit index], reset sample to 0, and increment the bit index. After bit DATA_BITS-1, go to STOP. Otherwise sample+1. Each data bit is sampled 16 ticks after the previous sample point.
- STOP: on a tick with sample=15:
  - rx_s=1: data<=shift, rdy<=1, overrun<=rdy (set if rdy already 1, else keep), go to IDLE.
  - rx_s=0: frame_err<=1, data and rdy unchanged, go to WAIT_HIGH.
- WAIT_HIGH: on a tick with rx_s=1, go to IDLE. This prevents a break condition from re-triggering immediately.
- rdy_clr=1 on any clock clears rdy, overrun and frame_err on that edge.
- If rdy_clr=1 on the same edge a frame completes, the set wins: rdy=1, and overrun uses the pre-clear rdy value.
- busy = (state != IDLE), registered with the state.
- Latency: rdy rises on the clock edge of the 16th tick of the stop bit. Counting from the rx falling edge that is 9.5 bit periods plus SYNC_STAGES cycles plus up to 1 tick of detection jitter.
- Counter widths: sample is 4 bits and wraps only under FSM control. The bit index is clog2(DATA_BITS)+1 bits.
- rxclk_en held at 1 continuously is legal. The block then runs at 16 cycles per bit.

Test Plan:
- rxclk_en tied 1. Send frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), each bit held 16 cycles. Required: data=8'hA5, rdy=1, frame_err=0, overrun=0, busy back to 0.
- Glitch: rx low for 4 ticks then high. Required: rdy stays 0, busy returns to 0 within 1 tick of rx_s going high. A following valid 0x3C frame is then received correctly.
- Frame 0x5A with stop bit 0, then rx held low for 3 bit periods, then high, then a valid 0x81 frame. Required: frame_err=1, data unchanged, rdy=0, and no spurious frame during the low period. After the valid frame: data=8'h81, rdy=1, frame_err still 1 until rdy_clr.
- Two back-to-back frames 0x11 then 0x22 with no rdy_clr. Required: data=8'h22, rdy=1, overrun=1. Then pulse rdy_clr: rdy=0, overrun=0.
- rdy_clr asserted on the exact completion edge of frame 0x7E while rdy=0. Required: rdy=1, overrun=0.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0xFF, release it, then send 0x0F. Required: all outputs 0 immediately on assert with no clock edge needed. The next frame yields data=8'h0F, rdy=1, with no partial byte.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver driven by a 16x oversample enable.
//
// The serial line is synchronised into the clk_50m domain. A start bit is
// accepted after 8 consecutive low ticks, which places the sample point at
// mid start bit. Each data bit (LSB first) and the stop bit are then sampled
// every 16 ticks, so each sample lands in the middle of its bit.
//
// Ports
//   clk_50m    in   system clock, 50 MHz
//   rst_n      in   asynchronous active-low reset
//   rxclk_en   in   one-cycle enable pulse, 16 per bit period
//   rx         in   serial line, idle high, asynchronous
//   rdy_clr    in   host acknowledge; clears rdy, overrun and frame_err
//   data       out  last correctly framed byte
//   rdy        out  a new byte is held in data
//   frame_err  out  sticky: a stop bit was sampled low
//   overrun    out  sticky: a byte completed while rdy was already 1
//   busy       out  receiver FSM is not idle
//
// Host handshake: rdy rises on the edge that completes a good frame and
// stays high until the host pulses rdy_clr. rdy_clr clears rdy, overrun and
// frame_err on the edge it is seen; if a frame completes on that same edge
// the set wins, and overrun is computed from rdy as it was before the clear.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 rxclk_en,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int BIT_W = IDX_W + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    // Synchroniser presets to 1 so reset looks like an idle line.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    state_t               state_q, state_n;
    logic [3:0]           sample_q, sample_n;
    logic [BIT_W-1:0]     bit_q, bit_n;
    logic [DATA_BITS-1:0] shift_q, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 rdy_n, frame_err_n, overrun_n;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sample_q  <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data      <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_n;
            sample_q  <= sample_n;
            bit_q     <= bit_n;
            shift_q   <= shift_n;
            data      <= data_n;
            rdy       <= rdy_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
            busy      <= (state_n != S_IDLE);
        end
    end

    always_comb begin
        state_n     = state_q;
        sample_n    = sample_q;
        bit_n       = bit_q;
        shift_n     = shift_q;
        data_n      = data;
        // The host clear applies first; frame completion below overrides it.
        rdy_n       = rdy_clr ? 1'b0 : rdy;
        frame_err_n = rdy_clr ? 1'b0 : frame_err;
        overrun_n   = rdy_clr ? 1'b0 : overrun;

        if (rxclk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_n  = S_START;
                        sample_n = 4'd1;
                    end
                end
                S_START: begin
                    if (rx_s) begin
                        // Glitch shorter than half a bit: not a start bit.
                        state_n  = S_IDLE;
                        sample_n = 4'd0;
                    end else if (sample_q == 4'd7) begin
                        state_n  = S_DATA;
                        sample_n = 4'd0;
                        bit_n    = '0;
                    end else begin
                        sample_n = sample_q + 4'd1;
                    end
                end
                S_DATA: begin
                    if (sample_q == 4'd15) begin
                        shift_n[bit_q[IDX_W-1:0]] = rx_s;
                        sample_n = 4'd0;
                        bit_n    = bit_q + BIT_W'(1);
                        if (bit_q == LAST_BIT) begin
                            state_n = S_STOP;
                        end
                    end else begin
                        sample_n = sample_q + 4'd1;
                    end
                end
                S_STOP: begin
                    if (sample_q == 4'd15) begin
                        sample_n = 4'd0;
                        if (rx_s) begin
                            data_n    = shift_q;
                            rdy_n     = 1'b1;
                            overrun_n = rdy | overrun_n;
                            state_n   = S_IDLE;
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = S_WAIT_HIGH;
                        end
                    end else begin
                        sample_n = sample_q + 4'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    // A held-low line (break) must return high before the
                    // next start bit can be recognised.
                    if (rx_s) begin
                        state_n = S_IDLE;
                    end
                end
                default: begin
                    state_n  = S_IDLE;
                    sample_n = 4'd0;
                end
            endcase
        end
    end

endmodule
